// File: rtl/sn74ls259_pkg.sv
// Shared definitions for the sn74ls259_sync addressable register: mode encoding
// built from {clr_n, g_n} and the one-hot address decode.
package sn74ls259_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DEMUX = 2'b00;
  localparam mode_t MODE_CLR   = 2'b01;
  localparam mode_t MODE_LATCH = 2'b10;
  localparam mode_t MODE_MEM   = 2'b11;

  localparam int unsigned MAX_AW = 8;
  localparam int unsigned MAX_W  = 1 << MAX_AW;

  // An unknown address bit makes every bit it could select unknown, since the
  // equality compare propagates X.
  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_AW-1:0] addr,
                                              input int unsigned width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) r[i] = (addr == MAX_AW'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/sn74ls259_ptr.sv
// Loadable AW-bit wrap counter: the auto-increment write pointer plus a
// one-cycle pulse marking the WIDTH-1 -> 0 rollover.
module sn74ls259_ptr #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic          inc,
  input  logic [AW-1:0] a,
  output logic [AW-1:0] ptr,
  output logic          wrap
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (ld) begin
      ptr  <= a;
      wrap <= 1'b0;
    end else if (inc) begin
      ptr  <= ptr + 1'b1;
      wrap <= (ptr == {AW{1'b1}});
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/sn74ls259.sv
// sn74ls259_sync: clocked 1-to-WIDTH addressable demux / latch register with an
// auto-increment write pointer and a tri-state output.
module sn74ls259_sync
  import sn74ls259_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic [AW-1:0]    a,
  input  logic             g_n,
  input  logic             clr_n,
  input  logic             ai,
  input  logic             ld,
  input  logic             oe_n,
  output logic [WIDTH-1:0] q,
  output logic [AW-1:0]    ptr,
  output logic             wrap
);

  if (WIDTH < 2 || (1 << AW) != WIDTH || AW > MAX_AW) begin : g_bad_params
    $error("sn74ls259_sync: WIDTH must be 2**AW, >= 2, AW <= %0d", MAX_AW);
  end

  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] dvec;
  logic [WIDTH-1:0] regs_p1;
  mode_t            mode;

  // The write always uses the pointer value from before this edge, even when
  // ld is reloading it at the same time.
  assign wa   = ai ? ptr : a;
  assign mode = {clr_n, g_n};
  assign mask = WIDTH'(onehot(MAX_AW'(wa), WIDTH));
  assign dvec = {WIDTH{d}};

  sn74ls259_ptr #(.AW(AW)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld),
    .inc   (ai & ~g_n),
    .a     (a),
    .ptr   (ptr),
    .wrap  (wrap)
  );

  // Stage p1: register array, updated once per edge according to the mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_p1 <= '0;
    end else begin
      case (mode)
        MODE_LATCH: regs_p1 <= (regs_p1 & ~mask) | (mask & dvec);
        MODE_MEM:   regs_p1 <= regs_p1;
        MODE_DEMUX: regs_p1 <= mask & dvec;
        MODE_CLR:   regs_p1 <= '0;
        default:    regs_p1 <= 'x;
      endcase
    end
  end

  assign q = oe_n ? {WIDTH{1'bz}} : regs_p1;

endmodule
